mux_nch_reg: RTL

- Parametrised N-channel, W-bit registered multiplexer with enable; the next generation of the team's 4:1 2-bit combinational mux.
- Adds a registered output stage with a valid/ready handshake and an auto-scan mode that cycles through the channels.
- Sits between parallel data sources and a single downstream consumer, for example a display or serial-out stage.

---
 rtl/mux_nch_reg_if.sv | 36 +++
 rtl/mux_nch_reg.sv | 112 +++++++++++
 2 files changed

// File: rtl/mux_nch_reg_if.sv
// Handshake/data bundle between parallel sources, mux_nch_reg and its consumer.
// Optional dout_par member present when MUX_NCH_PARITY_EN is defined.
interface mux_nch_reg_if #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic                   en;
  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   din;
  logic                   dout_ready;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic [SELW-1:0]        cur_sel;
  logic                   scan_wrap;
`ifdef MUX_NCH_PARITY_EN
  logic                   dout_par;
`endif

  modport master (
    output en, mode, sel, din, dout_ready,
    input  dout, dout_valid, cur_sel, scan_wrap
`ifdef MUX_NCH_PARITY_EN
    , input dout_par
`endif
  );

  modport slave (
    input  en, mode, sel, din, dout_ready,
    output dout, dout_valid, cur_sel, scan_wrap
`ifdef MUX_NCH_PARITY_EN
    , output dout_par
`endif
  );
endinterface

// File: rtl/mux_nch_reg.sv
// N-channel registered mux with valid/ready output stage and auto-scan pointer.
// Define MUX_NCH_PARITY_EN to add the registered even-parity output dout_par.
module mux_nch_reg #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nch_reg_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  function automatic logic f_even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic [SELW-1:0]  r_cur_sel;
  logic [SELW-1:0]  r_ptr;
  logic             r_scan_wrap;
  logic             r_dout_par;

  logic             w_load;
  logic [SELW-1:0]  w_src;
  logic [WIDTH-1:0] w_data;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_ch [2**SELW];

  // Pad the channel table to the full select range so unused indices read zero
  for (genvar k = 0; k < 2**SELW; k++) begin : g_ch
    if (k < NCH) begin : g_real
      assign w_ch[k] = bus.din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_ch[k] = '0;
    end
  end

  // Load decision, source selection and next scan pointer
  always_comb begin
    w_load    = bus.en && (!r_dout_valid || bus.dout_ready);
    w_src     = bus.mode ? r_ptr : bus.sel;
    w_data    = w_ch[w_src];
    if (r_ptr == LAST_CH) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_ptr + SELW'(1);
    end
  end

  // Output register, scan pointer and EMPTY/FULL state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_cur_sel    <= '0;
      r_ptr        <= '0;
      r_scan_wrap  <= 1'b0;
      r_dout_par   <= 1'b0;
    end else begin
      r_scan_wrap <= 1'b0;
      if (w_load) begin
        r_dout     <= w_data;
        r_cur_sel  <= w_src;
        r_dout_par <= f_even_par(w_data);
        if (bus.mode) begin
          r_ptr       <= w_ptr_nxt;
          r_scan_wrap <= (r_ptr == LAST_CH);
        end
      end
      case (r_state)
        ST_EMPTY: begin
          if (bus.en) begin
            r_state      <= ST_FULL;
            r_dout_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (bus.dout_ready && !bus.en) begin
            r_state      <= ST_EMPTY;
            r_dout_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.cur_sel    = r_cur_sel;
  assign bus.scan_wrap  = r_scan_wrap;
`ifdef MUX_NCH_PARITY_EN
  assign bus.dout_par   = r_dout_par;
`else
  logic w_par_unused;
  assign w_par_unused = r_dout_par;
`endif

endmodule
